// File: rtl/timekeeper_core.sv
// Timekeeper core: prescaled 24-hour BCD clock with a set-mode FSM, 12/24-hour
// display mapping and a single daily alarm. Everything runs on CLOCK_50.
module timekeeper_core #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned TICK_HZ  = 1,
    parameter bit          ALARM_EN = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       mode_p,
    input  logic       inc_p,
    input  logic       alarm_sel,
    input  logic       h12,
    input  logic       alarm_ack,
    output logic       tick,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       pm,
    output logic [1:0] state,
    output logic       alarm,
    output logic       day_carry
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StSetSec  = 2'd1,
        StSetMin  = 2'd2,
        StSetHour = 2'd3
    } state_e;

    // BCD increment that wraps to 00 after max, with no carry out.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 24-hour BCD to 12-hour BCD: 00 -> 12, 13..23 -> 01..11.
    function automatic logic [7:0] hour_to_12(input logic [7:0] h);
        logic [4:0] bin;
        logic [4:0] v;
        bin = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
        if (bin == 5'd0) begin
            v = 5'd12;
        end else if (bin > 5'd12) begin
            v = bin - 5'd12;
        end else begin
            v = bin;
        end
        if (v >= 5'd10) return {4'd1, 4'(v - 5'd10)};
        return {4'd0, v[3:0]};
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    state_e        state_q, state_d;
    logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [7:0]    alarm_min_q, alarm_min_d, alarm_hour_q, alarm_hour_d;
    logic          alarm_q, alarm_d;

    logic       run_tick, sec_wrap, min_wrap, match;
    logic [7:0] sec_inc, min_inc, hour_inc;
    logic [7:0] sec_t, min_t, hour_t;
    logic       show_alarm;
    logic [7:0] disp_hour;

    // Time base and run-mode counter chain, including the value after the next tick.
    always_comb begin
        tick      = (pre_q == PRE_MAX);
        pre_d     = tick ? '0 : pre_q + PW'(1);
        run_tick  = tick && (state_q == StRun);
        sec_inc   = bcd_inc(sec_q, 8'h59);
        min_inc   = bcd_inc(min_q, 8'h59);
        hour_inc  = bcd_inc(hour_q, 8'h23);
        sec_wrap  = (sec_q == 8'h59);
        min_wrap  = (min_q == 8'h59);
        sec_t     = sec_inc;
        min_t     = sec_wrap ? min_inc : min_q;
        hour_t    = (sec_wrap && min_wrap) ? hour_inc : hour_q;
        day_carry = run_tick && sec_wrap && min_wrap && (hour_q == 8'h23);
        match     = ALARM_EN && run_tick && (sec_t == 8'h00) &&
                    (min_t == alarm_min_q) && (hour_t == alarm_hour_q);
    end

    // Next-state: mode stepping (wins over inc), field edits, run-mode ticking, alarm flag.
    always_comb begin
        state_d      = state_q;
        sec_d        = sec_q;
        min_d        = min_q;
        hour_d       = hour_q;
        alarm_min_d  = alarm_min_q;
        alarm_hour_d = alarm_hour_q;

        if (run_tick) begin
            sec_d  = sec_t;
            min_d  = min_t;
            hour_d = hour_t;
        end

        if (mode_p) begin
            unique case (state_q)
                StRun:     state_d = StSetSec;
                StSetSec:  state_d = StSetMin;
                StSetMin:  state_d = StSetHour;
                StSetHour: state_d = StRun;
                default:   state_d = StRun;
            endcase
        end else if (inc_p) begin
            unique case (state_q)
                StSetSec: begin
                    if (!alarm_sel) sec_d = sec_inc;
                end
                StSetMin: begin
                    if (alarm_sel) alarm_min_d = bcd_inc(alarm_min_q, 8'h59);
                    else           min_d = min_inc;
                end
                StSetHour: begin
                    if (alarm_sel) alarm_hour_d = bcd_inc(alarm_hour_q, 8'h23);
                    else           hour_d = hour_inc;
                end
                default: ;
            endcase
        end

        // A match on the same cycle as an ack keeps the flag set.
        alarm_d = alarm_q;
        if (alarm_ack) alarm_d = 1'b0;
        if (match)     alarm_d = 1'b1;
    end

    // State registers with asynchronous reset to 00:00:00, alarm 07:00, RUN.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pre_q        <= '0;
            state_q      <= StRun;
            sec_q        <= 8'h00;
            min_q        <= 8'h00;
            hour_q       <= 8'h00;
            alarm_min_q  <= 8'h00;
            alarm_hour_q <= 8'h07;
            alarm_q      <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            state_q      <= state_d;
            sec_q        <= sec_d;
            min_q        <= min_d;
            hour_q       <= hour_d;
            alarm_min_q  <= alarm_min_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_q      <= alarm_d;
        end
    end

    // Display path: alarm registers while editing them, optional 12-hour mapping.
    always_comb begin
        show_alarm = alarm_sel && (state_q != StRun);
        disp_hour  = show_alarm ? alarm_hour_q : hour_q;
        sec_bcd    = show_alarm ? 8'h00 : sec_q;
        min_bcd    = show_alarm ? alarm_min_q : min_q;
        hour_bcd   = h12 ? hour_to_12(disp_hour) : disp_hour;
        pm         = (disp_hour >= 8'h12);
        state      = state_q;
        alarm      = ALARM_EN ? alarm_q : 1'b0;
    end

endmodule
